// File: rtl/fejkon_pcie_mem_access.sv
// Executes single-dword PCIe memory requests as Avalon-MM transactions, one at a time.
// Reads always yield a response: the slave's data or an error after a bounded wait.
module fejkon_pcie_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] req_data,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [127:0] resp_data,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [31:0]  avm_address,
  output logic         avm_read,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  output logic [3:0]   avm_byteenable,
  input  logic [31:0]  avm_readdata,
  input  logic         avm_readdatavalid,
  input  logic         avm_waitrequest,
  output logic [15:0]  stat_rd_count,
  output logic [15:0]  stat_wr_count,
  output logic [15:0]  stat_timeout_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_CMD  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_ready_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [7:0]  tag_q;
  logic [15:0] rid_q;
  logic [6:0]  lowaddr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] tmo_q;
  logic [15:0] rd_cnt_q, wr_cnt_q, to_cnt_q;

  logic accept, wr_done, rd_issue, rd_done, rd_expire;
  logic unused_req_bits;

  assign unused_req_bits = ^{req_data[127:103], req_data[71:69], req_data[33:32]};

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    wr_done   = 1'b0;
    rd_issue  = 1'b0;
    rd_done   = 1'b0;
    rd_expire = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          accept  = 1'b1;
          state_d = req_data[68] ? WRITE : READ_CMD;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      READ_CMD: begin
        rd_issue = !avm_waitrequest;
        if (tmo_q == TmoLast) begin
          rd_expire = 1'b1;
          state_d   = RESP;
        end else if (!avm_waitrequest) begin
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        // Data arriving in the expiry cycle still wins over the timeout.
        if (avm_readdatavalid) begin
          rd_done = 1'b1;
          state_d = RESP;
        end else if (tmo_q == TmoLast) begin
          rd_expire = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      tag_q       <= '0;
      rid_q       <= '0;
      lowaddr_q   <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      if (accept) begin
        wdata_q   <= req_data[31:0];
        addr_q    <= req_data[63:34];
        be_q      <= req_data[67:64];
        tag_q     <= req_data[79:72];
        rid_q     <= req_data[95:80];
        lowaddr_q <= req_data[102:96];
        tmo_q     <= '0;
      end else if (state_q == READ_CMD || state_q == READ_WAIT) begin
        tmo_q <= tmo_q + 16'd1;
      end
      if (rd_done) begin
        rdata_q <= avm_readdata;
        err_q   <= 1'b0;
      end else if (rd_expire) begin
        rdata_q <= '1;
        err_q   <= 1'b1;
      end
      if (wr_done)  wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rd_issue) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (rd_expire && to_cnt_q != '1) to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign req_ready          = req_ready_q;
  assign resp_valid         = (state_q == RESP);
  assign resp_data          = {64'b0, err_q, lowaddr_q, rid_q, tag_q, rdata_q};
  assign avm_address        = {addr_q, 2'b00};
  assign avm_read           = (state_q == READ_CMD);
  assign avm_write          = (state_q == WRITE);
  assign avm_writedata      = wdata_q;
  assign avm_byteenable     = be_q;
  assign stat_rd_count      = rd_cnt_q;
  assign stat_wr_count      = wr_cnt_q;
  assign stat_timeout_count = to_cnt_q;

endmodule

// File: doc/fejkon_pcie_mem_access.md
# fejkon_pcie_mem_access

Executes the single-dword memory requests that the PCIe TLP data path exports on its mem_access_req stream as Avalon-MM master transactions, and returns read results on the mem_access_resp stream for completion generation. It sits directly downstream of the PCIe data block's request source and upstream of its response sink, with the FIFOs between them instantiated in Qsys. One transaction is outstanding at a time. A read timeout guarantees that every read produces a response.

## Interface
- TIMEOUT_CYCLES, 1024: cycles a read may spend in READ_CMD plus READ_WAIT before it is terminated with an error response; legal range 2..65535.
- clk  in  1  sole clock; every port is synchronous to it.
- reset_n  in  1  reset, asynchronous and active-low.
- req_data  in  128  request word, see Operation.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- resp_data  out  128  response word, see Operation.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when high together with resp_valid.
- avm_address  out  32  byte address, bits [1:0] always 0.
- avm_read  out  1  Avalon-MM read.
- avm_write  out  1  Avalon-MM write.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  byte enables.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid.
- avm_waitrequest  in  1  slave stall.
- stat_rd_count  out  16  reads issued; wraps at 16 bits.
- stat_wr_count  out  16  writes issued; wraps at 16 bits.
- stat_timeout_count  out  16  reads terminated by timeout; saturates at 0xFFFF.

## Operation
- Request word fields:
  - [31:0] write data.
  - [63:32] address; bits [1:0] are ignored and forced to 0.
  - [67:64] first byte enable.
  - [68] is_write.
  - [79:72] tag.
  - [95:80] requester ID.
  - [102:96] lower address.
  - All other bits are ignored.
- Response word fields:
  - [31:0] read data.
  - [39:32] tag.
  - [55:40] requester ID.
  - [62:56] lower address.
  - [63] error.
  - All other bits are 0.
- Writes are posted and produce no response.
- A byte enable of 0 is passed through unchanged. For writes it still issues the write cycle.
- State machine states: IDLE, WRITE, READ_CMD, READ_WAIT, RESP.
- IDLE:
  - req_ready is 1.
  - On req_valid, latch every request field.
  - Go to WRITE if is_write is set, otherwise to READ_CMD.
- WRITE:
  - avm_write is 1; address, data and byteenable come from the latched values.
  - When avm_waitrequest is 0: increment stat_wr_count and go to IDLE.
- READ_CMD:
  - avm_read is 1.
  - When avm_waitrequest is 0: increment stat_rd_count and go to READ_WAIT.
- READ_WAIT:
  - On avm_readdatavalid, capture avm_readdata, set error to 0 and go to RESP.
- Timeout:
  - The timeout counter clears on entry to READ_CMD.
  - It increments on every cycle spent in READ_CMD or READ_WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion:
    - drop avm_read;
    - set read data to 0xFFFFFFFF and error to 1;
    - increment stat_timeout_count;
    - go to RESP.
  - Completion takes precedence: avm_readdatavalid arriving in the expiry cycle completes normally, with no error.
- avm_readdatavalid outside READ_WAIT (a late reply after a timeout) is ignored.
- RESP:
  - resp_valid is 1 and resp_data is held stable.
  - When resp_ready is 1, go to IDLE.
- resp_data is don't-care while resp_valid is 0.

## Timing
- Reset values of outputs:
  - req_ready, resp_valid, avm_read and avm_write are 0.
  - avm_address, avm_writedata, avm_byteenable and resp_data are 0.
  - All stat counters are 0.
  - The state is IDLE.
- req_ready goes to 1 on the first clk edge after reset_n is released.
- Request fields are registered on the accept edge. avm_read/avm_write assert in the next cycle. No combinational path exists from any input to avm_*.
- Avalon-MM outputs are held constant while avm_waitrequest is 1.
- Write throughput: 2 cycles per write with zero wait states.
- Read timing:
  - Slave read latency is 1 or more cycles.
  - resp_valid rises the cycle after avm_readdatavalid.
  - Minimum accept-to-resp_valid latency is 3 cycles.
- resp_valid never drops without a handshake.
- req_ready is 0 in every state except IDLE.
- Reset asserted mid-transaction:
  - Every output returns to its reset value immediately.
  - The in-flight transaction is lost.
  - No response is generated for it.

## Test plan
- Write, zero wait states:
  - Stimulus: req addr 0x100, data 0xDEADBEEF, byte enable 0xF, is_write 1.
  - Response: one avm_write cycle with those values; stat_wr_count = 1; no resp_valid.
- Read, waitrequest for 3 cycles, readdatavalid 2 cycles after acceptance:
  - Stimulus: addr 0x204, tag 0x2A, requester ID 0x0100, lower address 0x04; readdata 0x12345678.
  - Response: resp_data[31:0] = 0x12345678, tag 0x2A, requester ID 0x0100, lower address 0x04, error 0; stat_rd_count = 1.
- Read timeout:
  - Stimulus: TIMEOUT_CYCLES = 16; slave never asserts readdatavalid.
  - Response: response with data 0xFFFFFFFF and error 1, 16 cycles after READ_CMD entry; stat_timeout_count = 1.
  - Stimulus: a late readdatavalid, then a following read.
  - Response: the late readdatavalid is ignored; the following read completes correctly.
- Response backpressure:
  - Stimulus: hold resp_ready at 0 for 10 cycles while a second request waits.
  - Response: resp_data stays stable; req_ready stays 0; the second request is accepted only after the handshake.
- Reset mid-operation:
  - Stimulus: pulse reset_n low during READ_WAIT and during RESP.
  - Response: all outputs go to their reset values asynchronously; the next read after release behaves normally.
- Back-to-back stress:
  - Stimulus: 1000 random reads and writes with random waitrequest and read latency, checked against a memory model.
  - Response: all read data matches the model; the stat counters match the number of issued reads and writes.
